// File: rtl/dpram_streamer.sv
// Reads dpram_len words from a registered-output DPRAM and streams them MSB-first as bytes.
// Optional 4-byte header (0xBE 0xEF len_hi len_lo) enabled by defining DPRAM_STREAMER_HDR_EN.
module dpram_streamer #(
    parameter int P_ADDR_W = 10,
    parameter int P_LEN_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dpram_run,
    input  logic [P_LEN_W-1:0]  dpram_len,
    output logic                dpram_busy,
    output logic                dpram_done,
    output logic [P_ADDR_W-1:0] rd_addr,
    input  logic [31:0]         rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);

    localparam int DEPTH = 2 ** P_ADDR_W;
    localparam int CNT_W = P_LEN_W + 2;

`ifdef DPRAM_STREAMER_HDR_EN
    typedef enum logic [1:0] {IDLE, HDR, STREAM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
`endif

    state_t state_q, state_d;
    logic [P_LEN_W-1:0]  len_q, len_d, nreq_q, nreq_d, len_clamped;
    logic [P_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                req_q, req_d, rd_vld_q, rd_vld_d;
    logic [31:0]         cur_word_q, cur_word_d, skid_word_q, skid_word_d;
    logic                cur_vld_q, cur_vld_d, skid_vld_q, skid_vld_d;
    logic [1:0]          byte_sel_q, byte_sel_d;
    logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d, total_bytes;
    logic                beat, last_byte, cur_free, fetching;
    logic [1:0]          occ;

    assign len_clamped = (dpram_len > P_LEN_W'(DEPTH)) ? P_LEN_W'(DEPTH) : dpram_len;
    assign total_bytes = {len_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        nreq_d      = nreq_q;
        rd_addr_d   = rd_addr_q;
        cur_word_d  = cur_word_q;
        cur_vld_d   = cur_vld_q;
        skid_word_d = skid_word_q;
        skid_vld_d  = skid_vld_q;
        byte_sel_d  = byte_sel_q;
        tx_cnt_d    = tx_cnt_q;

        beat      = cur_vld_q && tx_ready;
        last_byte = beat && (byte_sel_q == 2'd3);
        cur_free  = !cur_vld_q || last_byte;

        if (beat) begin
            cur_word_d = {cur_word_q[23:0], 8'h00};
            byte_sel_d = byte_sel_q + 2'd1;
        end
        if (last_byte) begin
            cur_vld_d = 1'b0;
        end

        // The skid word always has priority over fresh RAM data so word order is preserved.
        if (cur_free && skid_vld_q) begin
            cur_word_d = skid_word_q;
            cur_vld_d  = 1'b1;
            byte_sel_d = 2'd0;
            skid_vld_d = 1'b0;
        end
        if (rd_vld_q) begin
            if (cur_free && !skid_vld_q) begin
                cur_word_d = rd_data;
                cur_vld_d  = 1'b1;
                byte_sel_d = 2'd0;
            end else begin
                skid_word_d = rd_data;
                skid_vld_d  = 1'b1;
            end
        end

        // Issue a read only when the word it returns is guaranteed a free slot on arrival.
        rd_vld_d = req_q;
        req_d    = 1'b0;
        occ      = 2'(cur_vld_d) + 2'(skid_vld_d) + 2'(req_q);
        fetching = (state_q != IDLE) && (state_q != DONE);
        if (fetching && (occ <= 2'd1) && (nreq_q < len_q)) begin
            req_d     = 1'b1;
            rd_addr_d = nreq_q[P_ADDR_W-1:0];
            nreq_d    = nreq_q + P_LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (dpram_run) begin
                    len_d    = len_clamped;
                    tx_cnt_d = '0;
                    // rd_addr already sits at 0 in IDLE, so word 0 is being read this cycle.
                    rd_vld_d = (len_clamped != '0);
                    nreq_d   = (len_clamped != '0) ? P_LEN_W'(1) : '0;
`ifdef DPRAM_STREAMER_HDR_EN
                    cur_word_d = {8'hBE, 8'hEF, 16'(len_clamped)};
                    cur_vld_d  = 1'b1;
                    byte_sel_d = 2'd0;
                    state_d    = HDR;
`else
                    state_d    = (len_clamped == '0) ? DONE : STREAM;
`endif
                end
            end
`ifdef DPRAM_STREAMER_HDR_EN
            HDR: begin
                if (last_byte) begin
                    state_d = (len_q == '0) ? DONE : STREAM;
                end
            end
`endif
            STREAM: begin
                if (beat) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    if (tx_cnt_q == total_bytes - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                rd_addr_d = '0;
                nreq_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            nreq_q      <= '0;
            rd_addr_q   <= '0;
            req_q       <= 1'b0;
            rd_vld_q    <= 1'b0;
            cur_word_q  <= '0;
            cur_vld_q   <= 1'b0;
            skid_word_q <= '0;
            skid_vld_q  <= 1'b0;
            byte_sel_q  <= '0;
            tx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            nreq_q      <= nreq_d;
            rd_addr_q   <= rd_addr_d;
            req_q       <= req_d;
            rd_vld_q    <= rd_vld_d;
            cur_word_q  <= cur_word_d;
            cur_vld_q   <= cur_vld_d;
            skid_word_q <= skid_word_d;
            skid_vld_q  <= skid_vld_d;
            byte_sel_q  <= byte_sel_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    assign dpram_busy = (state_q != IDLE) && (state_q != DONE);
    assign dpram_done = (state_q == DONE);
    assign rd_addr    = rd_addr_q;
    assign tx_data    = cur_word_q[31:24];
    assign tx_valid   = cur_vld_q;

endmodule

// File: tb/tb_dpram_streamer.sv
// Randomized bench for dpram_streamer: byte queue reference model built from RAM contents and len.
// Honors DPRAM_STREAMER_HDR_EN to expect the 4-byte header.
module tb_dpram_streamer;

    localparam int AW    = 10;
    localparam int LW    = 16;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          dpram_run;
    logic [LW-1:0] dpram_len;
    logic          dpram_busy, dpram_done;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_ready;

    logic [31:0]   mem [DEPTH];

    int asserts  = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    dpram_streamer #(.P_ADDR_W(AW), .P_LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .dpram_run (dpram_run),
        .dpram_len (dpram_len),
        .dpram_busy(dpram_busy),
        .dpram_done(dpram_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fillMem(input bit pattern);
        for (int i = 0; i < DEPTH; i++) mem[i] = pattern ? 32'h11223344 + 32'(i) : $urandom;
    endtask

    // mode 0: ready always high, 1: ready toggles 1010..., 2: random ready
    task automatic applyStimulus(input int len, input int mode, input bit stray_run);
        logic [7:0]  exp_q[$];
        logic [31:0] w;
        logic [7:0]  prev_data;
        int len_c, n_bytes, first_valid, last_beat, done_cyc, done_cnt, rd_max, cyc;
        bit prev_stall, finished;

        len_c = (len > DEPTH) ? DEPTH : len;
        exp_q.delete();
`ifdef DPRAM_STREAMER_HDR_EN
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'(len_c >> 8));
        exp_q.push_back(8'(len_c));
`endif
        for (int k = 0; k < len_c; k++) begin
            w = mem[k];
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        n_bytes = exp_q.size();

        @(posedge clk) #1;
        dpram_run = 1'b1;
        dpram_len = LW'(len);
        tx_ready  = 1'b1;
        @(posedge clk) #1;
        dpram_run = 1'b0;

        first_valid = -1; last_beat = -1; done_cyc = -1; done_cnt = 0; rd_max = 0;
        prev_stall = 1'b0; prev_data = '0; finished = 1'b0;
        for (cyc = 1; cyc < n_bytes * 4 + 50 && !finished; cyc++) begin
            tx_ready  = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc % 2) == 1) : 1'($urandom_range(0, 1));
            dpram_run = stray_run && (cyc == 4);
            dpram_len = (stray_run && cyc == 4) ? LW'(1) : LW'(len);
            @(negedge clk);
            if (cyc == 1) checkOutput("busy_start", dpram_busy, 32'(n_bytes > 0));
            if (prev_stall) begin
                checkOutput("stall_valid", tx_valid, 1);
                checkOutput("stall_data", tx_data, prev_data);
            end
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (dpram_busy && int'(rd_addr) > rd_max) rd_max = int'(rd_addr);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) checkOutput("extra_byte", tx_valid, 0);
                else checkOutput("byte", tx_data, exp_q.pop_front());
                last_beat = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (dpram_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                checkOutput("busy_at_done", dpram_busy, 0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                checkOutput("idle_valid", tx_valid, 0);
                checkOutput("idle_busy", dpram_busy, 0);
                finished = 1'b1;
            end
            @(posedge clk) #1;
        end
        dpram_run = 1'b0;

        checkOutput("finished_in_budget", finished, 1);
        checkOutput("bytes_left", exp_q.size(), 0);
        checkOutput("done_count", done_cnt, 1);
        if (n_bytes > 0) begin
            checkOutput("first_valid_latency_ok", 32'(first_valid >= 1 && first_valid <= 3), 1);
            checkOutput("done_after_last_beat", done_cyc, last_beat + 1);
            if (mode == 0) checkOutput("no_bubbles", last_beat - first_valid + 1, n_bytes);
        end else begin
            checkOutput("empty_done_latency_ok", 32'(done_cyc >= 1 && done_cyc <= 2), 1);
        end
        checkOutput("rd_addr_max", rd_max, (len_c > 0) ? len_c - 1 : 0);
        $display("[TB] frame len=%0d mode=%0d expected_bytes=%0d", len, mode, n_bytes);
    endtask

    task automatic resetMidFrame();
        int beats = 0;
        @(posedge clk) #1;
        dpram_run = 1'b1;
        dpram_len = LW'(4);
        tx_ready  = 1'b1;
        @(posedge clk) #1;
        dpram_run = 1'b0;
        for (int c = 0; c < 40 && beats < 5; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) beats++;
            if (beats < 5) @(posedge clk) #1;
        end
        checkOutput("rst_reached_byte5", beats, 5);
        rst = 1'b1;
        #1;
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_busy", dpram_busy, 0);
        checkOutput("rst_done", dpram_done, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_rd_addr", rd_addr, 0);
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_done", dpram_done, 0);
        checkOutput("post_rst_valid", tx_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        dpram_run = 1'b0;
        dpram_len = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", dpram_busy, 0);
        checkOutput("reset_done", dpram_done, 0);
        checkOutput("reset_valid", tx_valid, 0);
        checkOutput("reset_data", tx_data, 0);
        checkOutput("reset_rd_addr", rd_addr, 0);
        rst = 1'b0;

        fillMem(1'b1);
        applyStimulus(3, 0, 1'b0);
        applyStimulus(3, 1, 1'b0);
        applyStimulus(0, 0, 1'b0);
        fillMem(1'b0);
        applyStimulus(2000, 0, 1'b0);
        applyStimulus(5, 2, 1'b1);
        resetMidFrame();
        applyStimulus(1, 0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(int'($urandom_range(1, 20)), 2, 1'b0);
        applyStimulus(2, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
